disp_stream_formatter: RTL and testbench

Downstream stage of the stereovision core. It takes the disparity AXI4-Stream the core produces (4 samples/clock, 24-bit sample slots), scales each disparity into an 8-bit grey level, and replicates it onto R, G and B for the video output path. It also checks frame and line framing against the configured geometry, reports sticky errors and counts frames. A skid buffer absorbs backpressure from the video sink.

---
 rtl/stereo_pkg.sv | 24 ++
 rtl/axis_skid_buffer.sv | 57 +++++
 rtl/disp_stream_formatter.sv | 120 ++++++++++++
 tb/tb_disp_stream_formatter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared types and helpers for the stereovision output path.
// Sample slots are 24 bits wide; disparity-to-grey scaling saturates at 8'hFF.
package stereo_pkg;

    localparam int SAMPLE_SLOT_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_slot_t;

    function automatic int calc_bpl(input int width, input int spc);
        return width / spc;
    endfunction

    // Left shift by sh; any set bit pushed past bit 7 clamps the result to full scale.
    function automatic logic [7:0] sat_shl(input logic [15:0] d, input logic [2:0] sh);
        logic [23:0] wide;
        wide = {8'd0, d} << sh;
        return (|wide[23:8]) ? 8'hFF : wide[7:0];
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer with a registered s_ready.
// s_ready depends only on occupancy, so no combinational path runs from m_ready upstream.
module axis_skid_buffer #(
    parameter int DW = 98
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          push;
    logic          pop;

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count   <= count_next;
            s_ready <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/disp_stream_formatter.sv
// Disparity stream to grey RGB: per-slot saturating gain, framing checks,
// sticky error flags and a frame counter, with a skid buffer toward the video sink.
module disp_stream_formatter
    import stereo_pkg::*;
#(
    parameter int WIDTH                 = 3840,
    parameter int HEIGHT                = 2160,
    parameter int MAX_SAMPLES_PER_CLOCK = 4,
    parameter int AXIS_TDATA_WIDTH      = 96,
    parameter int DATA_WIDTH            = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tuser,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    input  logic [2:0]                  gain_shift,
    input  logic                        err_clear,
    output logic                        err_early_eol,
    output logic                        err_late_eol,
    output logic                        err_sof,
    output logic [15:0]                 frame_count
);

    localparam int BPL = calc_bpl(WIDTH, MAX_SAMPLES_PER_CLOCK);
    localparam int XW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int YW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(BPL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [2:0]    gain_q;
    logic [2:0]    gain_eff;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          accept;
    logic          at_last;
    logic          eol;
    logic          sof_bad;
    logic          early;
    logic          late;

    rgb_slot_t [MAX_SAMPLES_PER_CLOCK-1:0] pix;

    assign accept   = s_axis_tvalid & s_axis_tready;
    // The start-of-frame beat already runs at the newly latched gain.
    assign gain_eff = s_axis_tuser ? gain_shift : gain_q;

    genvar k;
    generate
        for (k = 0; k < MAX_SAMPLES_PER_CLOCK; k++) begin : g_lane
            logic [7:0] grey;
            logic       unused_hi;
            assign grey      = sat_shl(16'(s_axis_tdata[k*SAMPLE_SLOT_W +: DATA_WIDTH]), gain_eff);
            assign pix[k]    = '{r: grey, g: grey, b: grey};
            assign unused_hi = ^s_axis_tdata[k*SAMPLE_SLOT_W+DATA_WIDTH +: SAMPLE_SLOT_W-DATA_WIDTH];
        end
    endgenerate

    // A start-of-frame beat is evaluated as if it sat at (0,0).
    assign cur_x   = s_axis_tuser ? '0 : x;
    assign cur_y   = s_axis_tuser ? '0 : y;
    assign at_last = (cur_x == X_LAST);
    assign eol     = s_axis_tlast | at_last;
    assign sof_bad = s_axis_tuser & ((x != '0) | (y != '0));
    assign early   = s_axis_tlast & ~at_last;
    assign late    = at_last & ~s_axis_tlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            gain_q        <= 3'd0;
            x             <= '0;
            y             <= '0;
            frame_count   <= 16'd0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_sof       <= 1'b0;
        end else begin
            if (accept) begin
                if (s_axis_tuser) begin
                    gain_q      <= gain_shift;
                    frame_count <= frame_count + 16'd1;
                end
                if (eol) begin
                    x <= '0;
                    y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
                end else begin
                    x <= cur_x + 1'b1;
                    y <= cur_y;
                end
            end
            // A new error in the clearing cycle still sets its flag.
            err_early_eol <= (err_early_eol & ~err_clear) | (accept & early);
            err_late_eol  <= (err_late_eol  & ~err_clear) | (accept & late);
            err_sof       <= (err_sof       & ~err_clear) | (accept & sof_bad);
        end
    end

    axis_skid_buffer #(
        .DW(AXIS_TDATA_WIDTH + 2)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  ({s_axis_tuser, s_axis_tlast, AXIS_TDATA_WIDTH'(pix)}),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_disp_stream_formatter.sv
// Scoreboard bench for disp_stream_formatter at WIDTH=16, HEIGHT=4 (4 beats per line).
module tb_disp_stream_formatter;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int SPC = 4;
    localparam int TW  = 96;
    localparam int BPL = W / SPC;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [TW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic          s_tready;
    logic [TW-1:0] m_tdata;
    logic          m_tvalid, m_tuser, m_tlast;
    logic          m_tready = 1'b0;
    logic [2:0]    gain_shift = 3'd0;
    logic          err_clear = 1'b0;
    logic          err_early_eol, err_late_eol, err_sof;
    logic [15:0]   frame_count;

    always #5 aclk = ~aclk;

    disp_stream_formatter #(
        .WIDTH(W), .HEIGHT(H), .MAX_SAMPLES_PER_CLOCK(SPC),
        .AXIS_TDATA_WIDTH(TW), .DATA_WIDTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .gain_shift(gain_shift), .err_clear(err_clear),
        .err_early_eol(err_early_eol), .err_late_eol(err_late_eol), .err_sof(err_sof),
        .frame_count(frame_count)
    );

    typedef struct {
        logic [TW+1:0] beat;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 0, bp_mode = 0, gap_mode = 0, hold_ready = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        if (hold_ready)   m_tready = 1'b0;
        else if (bp_mode) m_tready = ($urandom_range(0, 9) < 3);
        else              m_tready = 1'b1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] grey(input logic [7:0] d, input int g);
        int w;
        w = int'(d) << g;
        return (w > 255) ? 8'hFF : 8'(w);
    endfunction

    // Output monitor: pops the scoreboard on every m_axis handshake and checks stall stability.
    bit            p_stall = 0;
    logic [TW+2:0] p_out;
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn === 1'b1) begin
            if (p_stall) chk("hold_stable", 128'({m_tvalid, m_tuser, m_tlast, m_tdata}), 128'(p_out));
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", {m_tuser, m_tlast, m_tdata});
                end else begin
                    e = sb.pop_front();
                    chk("out_beat", 128'({m_tuser, m_tlast, m_tdata}), 128'(e.beat));
                    if (lat_chk) chk("latency", 128'(cyc), 128'(e.cyc));
                end
            end
            p_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            p_out   = {m_tvalid, m_tuser, m_tlast, m_tdata};
        end else begin
            p_stall = 0;
        end
    end

    // Occupancy model built from observed handshakes; a full buffer must not advertise ready.
    int occ = 0;
    bit p_acc = 0, p_xfer = 0, p_rst = 1;
    always @(negedge aclk) begin
        if (p_rst) occ = 0;
        else       occ = occ + int'(p_acc) - int'(p_xfer);
        if (occ == 2 && aresetn === 1'b1) chk("ready_when_full", 128'(s_tready), 128'(0));
        p_rst  = (aresetn !== 1'b1);
        p_acc  = (s_tvalid === 1'b1) && (s_tready === 1'b1);
        p_xfer = (m_tvalid === 1'b1) && (m_tready === 1'b1);
    end

    task automatic beat(input bit u, input bit l, input logic [31:0] dv, input logic [TW-1:0] ed);
        exp_t e;
        int   n;
        if (gap_mode) begin
            n = $urandom_range(0, 2);
            if (n > 0) begin
                repeat (n) @(posedge aclk);
                #1;
            end
        end
        for (int k = 0; k < SPC; k++)
            s_tdata[24*k +: 24] = {16'hA5C3 ^ 16'(k * 4097), dv[8*k +: 8]};
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (s_tready !== 1'b1 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (s_tready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got tready=%b expected 1", s_tready);
            s_tvalid = 1'b0;
            return;
        end
        e.beat = {u, l, ed};
        e.cyc  = cyc + 1;
        sb.push_back(e);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic beatm(input bit u, input bit l, input logic [31:0] dv, input int g);
        logic [TW-1:0] ed;
        for (int k = 0; k < SPC; k++) ed[24*k +: 24] = {3{grey(dv[8*k +: 8], g)}};
        beat(u, l, dv, ed);
    endtask

    // n beats of random data; first carries tuser if sof, last carries tlast=tl.
    task automatic run(input int g, input bit sof, input int n, input bit tl);
        for (int i = 0; i < n; i++)
            beatm(sof && i == 0, (i == n - 1) ? tl : 1'b0, $urandom, g);
    endtask

    task automatic frame(input int g);
        gain_shift = 3'(g);
        run(g, 1, BPL, 1);
        for (int yy = 1; yy < H; yy++) run(g, 0, BPL, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || m_tvalid === 1'b1) && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    task automatic chk_flags(input string name, input logic [2:0] exp);
        chk(name, 128'({err_early_eol, err_late_eol, err_sof}), 128'(exp));
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        sb.delete();
        chk("rst_tready", 128'(s_tready), 128'(0));
        chk("rst_mvalid", 128'({m_tvalid, m_tuser, m_tlast}), 128'(0));
        chk("rst_mdata", 128'(m_tdata), 128'(0));
        chk_flags("rst_flags", 3'b000);
        chk("rst_fcount", 128'(frame_count), 128'(0));
        hold_ready = 0;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("tready_after_rst", 128'(s_tready), 128'(1));
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        do_reset();

        // Gain and saturation: slots 0,63,64,255 at gain 2.
        gain_shift = 3'd2;
        beat(1, 0, 32'hFF403F00, {24'hFFFFFF, 24'hFFFFFF, 24'hFCFCFC, 24'h000000});
        run(2, 0, BPL - 1, 1);
        for (int yy = 1; yy < H; yy++) run(2, 0, BPL, 1);
        drain();
        chk_flags("gain_frame_flags", 3'b000);
        chk("gain_frame_count", 128'(frame_count), 128'(1));

        // Clean back-to-back frames with one-cycle latency.
        do_reset();
        lat_chk = 1;
        frame(0);
        frame(5);
        drain();
        lat_chk = 0;
        chk_flags("clean_flags", 3'b000);
        chk("clean_frame_count", 128'(frame_count), 128'(2));

        // Early end of line at x=2 of line 1.
        gain_shift = 3'd1;
        run(1, 1, BPL, 1);
        run(1, 0, 3, 1);
        chk_flags("early_set", 3'b100);
        run(1, 0, BPL, 1);
        run(1, 0, BPL, 1);
        chk_flags("early_sticky", 3'b100);
        pulse_clear();
        chk_flags("early_cleared", 3'b000);
        frame(4);
        chk_flags("after_early_sof_ok", 3'b000);

        // Late end of line, then a start of frame at x=1 with a concurrent clear.
        gain_shift = 3'd1;
        run(1, 1, BPL, 0);
        chk_flags("late_set", 3'b010);
        run(1, 0, 1, 0);
        gain_shift = 3'd6;
        err_clear = 1'b1;
        run(6, 1, 1, 0);
        err_clear = 1'b0;
        chk_flags("sof_set_clear_same_cycle", 3'b001);
        pulse_clear();
        run(6, 0, BPL - 1, 1);
        for (int yy = 1; yy < H; yy++) run(6, 0, BPL, 1);
        chk_flags("sof_restart_ok", 3'b000);

        // Gain change mid-frame applies only from the next tuser beat.
        gain_shift = 3'd1;
        run(1, 1, BPL, 1);
        gain_shift = 3'd3;
        for (int yy = 1; yy < H; yy++) run(1, 0, BPL, 1);
        frame(3);
        drain();
        chk_flags("gain_change_flags", 3'b000);

        // Backpressure: 30% ready duty, random input gaps, 63 frames (1008 beats).
        bp_mode = 1;
        gap_mode = 1;
        for (int f = 0; f < 63; f++) frame(int'($urandom_range(0, 7)));
        drain();
        bp_mode = 0;
        gap_mode = 0;
        chk_flags("bp_flags", 3'b000);

        // Reset mid-line with both buffer entries held.
        hold_ready = 1;
        @(posedge aclk);
        #2;
        run(2, 1, 2, 0);
        do_reset();
        frame(3);
        drain();
        chk_flags("post_reset_flags", 3'b000);
        chk("post_reset_fcount", 128'(frame_count), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
